// File: rtl/mdu_hilo.sv
// Multiply/divide unit owning the HI/LO registers of the MIPS Execute stage.
// Optional MADD/MADDU accumulate support is enabled by defining MDU_MADD_EN.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hilo_out
);

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MFHI  = 4'd4,
        OP_MFLO  = 4'd5,
        OP_MTHI  = 4'd6,
        OP_MTLO  = 4'd7,
        OP_MADD  = 4'd8,
        OP_MADDU = 4'd9
    } mdu_op_e;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    logic [31:0]      r_hi, r_lo;
    logic [31:0]      r_phi, r_plo;
    logic [CNT_W-1:0] r_count;
    logic             r_dz;

    logic               w_acc;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic [63:0]        w_div_s;
    logic [63:0]        w_div_u;

    // Divide via magnitudes so the most-negative / -1 case wraps cleanly
    // instead of relying on the simulator's signed-overflow behaviour.
    // Result packs {remainder, quotient}.
    function automatic logic [63:0] div_rq(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        ma = (sgn && a[31]) ? (~a + 32'd1) : a;
        mb = (sgn && b[31]) ? (~b + 32'd1) : b;
        if (mb == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (sgn && (a[31] ^ b[31])) q = ~q + 32'd1;
        if (sgn && a[31])           r = ~r + 32'd1;
        return {r, q};
    endfunction

    assign w_acc    = start & ~req & (r_count == '0);
    assign w_prod_s = $signed(rs_val) * $signed(rt_val);
    assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    assign w_div_s  = div_rq(rs_val, rt_val, 1'b1);
    assign w_div_u  = div_rq(rs_val, rt_val, 1'b0);

    assign busy = (r_count != '0);

    always_comb begin
        hilo_out = 32'd0;
        if (op == OP_MFHI)      hilo_out = r_hi;
        else if (op == OP_MFLO) hilo_out = r_lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_phi   <= 32'd0;
            r_plo   <= 32'd0;
            r_count <= '0;
            r_dz    <= 1'b0;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
            if (r_count == CNT_W'(1) && !r_dz) begin
                r_hi <= r_phi;
                r_lo <= r_plo;
            end
        end else if (w_acc) begin
            case (op)
                OP_MULT: begin
                    {r_phi, r_plo} <= w_prod_s;
                    r_count        <= MULT_CNT;
                    r_dz           <= 1'b0;
                end
                OP_MULTU: begin
                    {r_phi, r_plo} <= w_prod_u;
                    r_count        <= MULT_CNT;
                    r_dz           <= 1'b0;
                end
                OP_DIV: begin
                    {r_phi, r_plo} <= w_div_s;
                    r_count        <= DIV_CNT;
                    r_dz           <= (rt_val == 32'd0);
                end
                OP_DIVU: begin
                    {r_phi, r_plo} <= w_div_u;
                    r_count        <= DIV_CNT;
                    r_dz           <= (rt_val == 32'd0);
                end
                OP_MTHI: r_hi <= rs_val;
                OP_MTLO: r_lo <= rs_val;
`ifdef MDU_MADD_EN
                OP_MADD: begin
                    {r_phi, r_plo} <= {r_hi, r_lo} + w_prod_s;
                    r_count        <= MULT_CNT;
                    r_dz           <= 1'b0;
                end
                OP_MADDU: begin
                    {r_phi, r_plo} <= {r_hi, r_lo} + w_prod_u;
                    r_count        <= MULT_CNT;
                    r_dz           <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
